// File: rtl/ctrl_contador_3b_pkg.sv
// ctrl3_pkg: shared encodings for the ctrl_contador_3b step controller.
//   - FSM state encoding (IDLE / ISSUE / ACK)
//   - step direction and requester id constants
//   - step_out_of_range(): saturation check used before issuing a step
package ctrl3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    ACK   = 2'b10
  } ctrl3_state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam logic ID_M = 1'b0;
  localparam logic ID_A = 1'b1;

  // True when a step in direction dir starting from q would leave [minv, maxv].
  function automatic logic step_out_of_range(input logic       dir,
                                             input logic [2:0] q,
                                             input logic [2:0] maxv,
                                             input logic [2:0] minv);
    if (dir == DIR_UP) return (q >= maxv);
    else               return (q <= minv);
  endfunction

endpackage

// File: rtl/ctrl_contador_3b_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter.
// Ports:
//   clk3, reset3  clock, asynchronous active-high reset
//   req[1:0]      request vector, bit index = requester id (ID_M / ID_A)
//   gnt_en        commit the current grant (advances the pointer)
//   gnt_vld       some request is pending (combinational)
//   gnt_id        id of the winner (combinational)
// The pointer holds the id granted last; out of reset it reads "auto last"
// so the manual channel wins the first tie.
module rr_arb2
  import ctrl3_pkg::*;
(
  input  logic       clk3,
  input  logic       reset3,
  input  logic [1:0] req,
  input  logic       gnt_en,
  output logic       gnt_vld,
  output logic       gnt_id
);

  logic last_q;

  always_comb begin
    gnt_vld = |req;
    gnt_id  = ID_M;
    if (req == 2'b11)
      gnt_id = (last_q == ID_M) ? ID_A : ID_M;
    else if (req[ID_A])
      gnt_id = ID_A;
  end

  always_ff @(posedge clk3 or posedge reset3) begin
    if (reset3)
      last_q <= ID_A;
    else if (gnt_en && gnt_vld)
      last_q <= gnt_id;
  end

endmodule

// File: rtl/ctrl_contador_3b.sv
// ctrl_contador_3b: arbitrating step controller for the 3-bit up/down counter.
// Two requesters (manual, auto) each ask for one up/down step; grants are
// round-robin, each accepted step pulses en3 with up3 or down3 for one cycle,
// and every request is acknowledged (with err when the step was refused).
// Ports:
//   clk3, reset3       clock, asynchronous active-high reset
//   req_m, dir_m       manual request level and direction (1 = up)
//   req_a, dir_a       auto request level and direction (1 = up)
//   q3[2:0]            counter value fed back from the counter
//   en3, up3, down3    registered counter command, one-cycle pulse per step
//   ack_m, ack_a       one-cycle completion pulse per requester
//   err                pulses with the ack of a refused step
//   busy               high in every state except IDLE
// Macro CTRL3_WRAP_EN: when defined the range check is removed, every step is
// issued and the counter wraps; err never asserts.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting; arbitrates pending requests and range-checks the winner
// ISSUE | en3 with up3/down3 asserted for the latched step
// ACK   | winner's ack pulsed (with err if the step was refused)
module ctrl_contador_3b
  import ctrl3_pkg::*;
#(
  parameter logic [2:0] MAXV = 3'd7,
  parameter logic [2:0] MINV = 3'd0
) (
  input  logic       clk3,
  input  logic       reset3,
  input  logic       req_m,
  input  logic       dir_m,
  input  logic       req_a,
  input  logic       dir_a,
  input  logic [2:0] q3,
  output logic       en3,
  output logic       up3,
  output logic       down3,
  output logic       ack_m,
  output logic       ack_a,
  output logic       err,
  output logic       busy
);

  ctrl3_state_e state_q, state_nx;
  logic         id_q, id_nx;
  logic         dir_q, dir_nx;
  logic         refuse_q, refuse_nx;

  logic gnt_en, gnt_vld, gnt_id;
  logic dir_cand, refuse_cand;

  logic en3_nx, up3_nx, down3_nx, ack_m_nx, ack_a_nx, err_nx, busy_nx;

  rr_arb2 u_arb (
    .clk3    (clk3),
    .reset3  (reset3),
    .req     ({req_a, req_m}),
    .gnt_en  (gnt_en),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  assign dir_cand = (gnt_id == ID_A) ? dir_a : dir_m;

`ifdef CTRL3_WRAP_EN
  assign refuse_cand = 1'b0;
`else
  assign refuse_cand = step_out_of_range(dir_cand, q3, MAXV, MINV);
`endif

  always_comb begin
    state_nx  = state_q;
    id_nx     = id_q;
    dir_nx    = dir_q;
    refuse_nx = refuse_q;
    gnt_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          gnt_en    = 1'b1;
          id_nx     = gnt_id;
          dir_nx    = dir_cand;
          refuse_nx = refuse_cand;
          state_nx  = refuse_cand ? ACK : ISSUE;
        end
      end
      ISSUE:   state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Outputs are computed from the next state so they register alongside it.
    en3_nx   = (state_nx == ISSUE);
    up3_nx   = en3_nx && (dir_nx == DIR_UP);
    down3_nx = en3_nx && (dir_nx == DIR_DN);
    ack_m_nx = (state_nx == ACK) && (id_nx == ID_M);
    ack_a_nx = (state_nx == ACK) && (id_nx == ID_A);
    err_nx   = (state_nx == ACK) && refuse_nx;
    busy_nx  = (state_nx != IDLE);
  end

  always_ff @(posedge clk3 or posedge reset3) begin
    if (reset3) begin
      state_q  <= IDLE;
      id_q     <= ID_M;
      dir_q    <= DIR_DN;
      refuse_q <= 1'b0;
      en3      <= 1'b0;
      up3      <= 1'b0;
      down3    <= 1'b0;
      ack_m    <= 1'b0;
      ack_a    <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_nx;
      id_q     <= id_nx;
      dir_q    <= dir_nx;
      refuse_q <= refuse_nx;
      en3      <= en3_nx;
      up3      <= up3_nx;
      down3    <= down3_nx;
      ack_m    <= ack_m_nx;
      ack_a    <= ack_a_nx;
      err      <= err_nx;
      busy     <= busy_nx;
    end
  end

endmodule

// File: tb/tb_ctrl_contador_3b.sv
// tb_ctrl_contador_3b: self-checking bench for ctrl_contador_3b.
// A behavioural 3-bit counter closes the q3 loop; expected acks are queued
// when requests are driven and popped by a monitor when an ack appears.
// Builds with or without CTRL3_WRAP_EN.
module tb_ctrl_contador_3b;
  import ctrl3_pkg::*;

`ifdef CTRL3_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk3 = 1'b0;
  logic       reset3 = 1'b1;
  logic       req_m = 1'b0, dir_m = 1'b0, req_a = 1'b0, dir_a = 1'b0;
  logic [2:0] q3 = 3'd0;
  logic       en3, up3, down3, ack_m, ack_a, err, busy;

  logic       load_en = 1'b0;
  logic [2:0] load_val = 3'd0;

  typedef struct packed {
    logic       id;
    logic       err;
    logic [2:0] q;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   en_cnt = 0;

  ctrl_contador_3b dut (
    .clk3   (clk3),
    .reset3 (reset3),
    .req_m  (req_m),
    .dir_m  (dir_m),
    .req_a  (req_a),
    .dir_a  (dir_a),
    .q3     (q3),
    .en3    (en3),
    .up3    (up3),
    .down3  (down3),
    .ack_m  (ack_m),
    .ack_a  (ack_a),
    .err    (err),
    .busy   (busy)
  );

  always #5 clk3 = ~clk3;

  // counter model (contador_3_bits) with a bench-side load port
  always @(posedge clk3) begin
    if (load_en)    q3 <= load_val;
    else if (en3 && up3)   q3 <= q3 + 3'd1;
    else if (en3 && down3) q3 <= q3 - 3'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk3) begin
    if (!reset3) begin
      if (en3) en_cnt++;
      if (en3 || up3 || down3)
        chk("cmd_legal", {30'd0, en3, up3 ^ down3}, 32'd3);
      if (ack_m || ack_a) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", {30'd0, ack_a, ack_m}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_id_err_q", {26'd0, ack_m, ack_a, err, q3},
              {26'd0, ~e.id, e.id, e.err, e.q});
        end
      end else if (err) begin
        chk("err_without_ack", {31'd0, err}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk3);
    #1;
  endtask

  task automatic do_reset();
    reset3 = 1'b1;
    tick();
    tick();
    reset3 = 1'b0;
  endtask

  task automatic set_q(input logic [2:0] v);
    load_val = v;
    load_en  = 1'b1;
    tick();
    load_en  = 1'b0;
  endtask

  task automatic wait_ack(input int max, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk3);
      cyc++;
    end while (!(ack_m || ack_a) && cyc < max);
    if (!(ack_m || ack_a))
      chk("ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int en0;

    // reset state
    @(negedge clk3);
    chk("rst_outs", {25'd0, en3, up3, down3, ack_m, ack_a, err, busy}, 32'd0);

    // single accepted up step with cycle-exact timing
    do_reset();
    set_q(3'd3);
    req_m = 1'b1; dir_m = DIR_UP;
    sb.push_back('{id: ID_M, err: 1'b0, q: 3'd4});
    @(negedge clk3);
    chk("t1_c0_idle", {30'd0, en3, busy}, 32'd0);
    @(negedge clk3);
    chk("t1_c1_issue", {27'd0, en3, up3, down3, busy, ack_m}, 32'b11010);
    @(negedge clk3);
    chk("t1_c2_ack", {28'd0, en3, ack_m, err, busy}, 32'b0101);
    tick();
    req_m = 1'b0;
    @(negedge clk3);
    chk("t1_c3_idle", {31'd0, busy}, 32'd0);

    // contention from q3 = 0: m, a, m, a, one step every 3 cycles
    do_reset();
    set_q(3'd0);
    req_m = 1'b1; dir_m = DIR_UP;
    req_a = 1'b1; dir_a = DIR_UP;
    sb.push_back('{id: ID_M, err: 1'b0, q: 3'd1});
    sb.push_back('{id: ID_A, err: 1'b0, q: 3'd2});
    sb.push_back('{id: ID_M, err: 1'b0, q: 3'd3});
    sb.push_back('{id: ID_A, err: 1'b0, q: 3'd4});
    for (int i = 0; i < 4; i++) begin
      wait_ack(8, cyc);
      chk(i == 0 ? "t2_first_lat" : "t2_period", cyc, 32'd3);
    end
    tick();
    req_m = 1'b0; req_a = 1'b0;
    repeat (3) tick();

    // up at the top of the range
    set_q(3'd7);
    en0 = en_cnt;
    req_a = 1'b1; dir_a = DIR_UP;
    sb.push_back('{id: ID_A, err: !WRAP, q: WRAP ? 3'd0 : 3'd7});
    wait_ack(8, cyc);
    chk("t3_up_lat", cyc, WRAP ? 32'd3 : 32'd2);
    tick();
    req_a = 1'b0;
    chk("t3_up_en_cnt", en_cnt - en0, WRAP ? 32'd1 : 32'd0);
    tick();

    // down at the bottom of the range
    set_q(3'd0);
    en0 = en_cnt;
    req_m = 1'b1; dir_m = DIR_DN;
    sb.push_back('{id: ID_M, err: !WRAP, q: WRAP ? 3'd7 : 3'd0});
    wait_ack(8, cyc);
    chk("t3_dn_lat", cyc, WRAP ? 32'd3 : 32'd2);
    tick();
    req_m = 1'b0;
    chk("t3_dn_en_cnt", en_cnt - en0, WRAP ? 32'd1 : 32'd0);
    tick();

    // request dropped during ISSUE, auto arriving while busy, held auto req
    set_q(3'd2);
    req_m = 1'b1; dir_m = DIR_UP;
    sb.push_back('{id: ID_M, err: 1'b0, q: 3'd3});
    tick();
    req_m = 1'b0; dir_m = DIR_DN;
    req_a = 1'b1; dir_a = DIR_DN;
    sb.push_back('{id: ID_A, err: 1'b0, q: 3'd2});
    sb.push_back('{id: ID_A, err: 1'b0, q: 3'd1});
    wait_ack(8, cyc);
    chk("t4_m_lat", cyc, 32'd2);
    wait_ack(8, cyc);
    chk("t4_a_wait", cyc, 32'd3);
    wait_ack(8, cyc);
    chk("t4_a_held", cyc, 32'd3);
    tick();
    req_a = 1'b0;
    repeat (2) tick();

    // reset during ISSUE drops the step and restores the tie pointer
    set_q(3'd4);
    req_m = 1'b1; dir_m = DIR_DN;
    tick();
    #1;
    reset3 = 1'b1;
    req_m  = 1'b0;
    @(negedge clk3);
    chk("t5_rst_async", {30'd0, en3, busy}, 32'd0);
    tick();
    reset3 = 1'b0;
    @(negedge clk3);
    chk("t5_no_ack", {28'd0, en3, ack_m, ack_a, busy}, 32'd0);
    chk("t5_q_kept", {29'd0, q3}, 32'd4);
    tick();
    req_m = 1'b1; dir_m = DIR_DN;
    req_a = 1'b1; dir_a = DIR_DN;
    sb.push_back('{id: ID_M, err: 1'b0, q: 3'd3});
    sb.push_back('{id: ID_A, err: 1'b0, q: 3'd2});
    wait_ack(8, cyc);
    chk("t5_tie_lat", cyc, 32'd3);
    tick();
    req_m = 1'b0;
    wait_ack(8, cyc);
    chk("t5_a_lat", cyc, 32'd3);
    tick();
    req_a = 1'b0;

    repeat (4) tick();
    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_contador_3b.md
# ctrl_contador_3b

Arbitrating step controller for the 3-bit up/down counter `contador_3_bits`. Two requesters share the single counter: a manual channel from the pushbutton front end and an automatic channel from the sweep logic. Each requester asks for a single up or down step. The block grants requesters round-robin and drives the counter's `en3`/`up3`/`down3` for exactly one cycle per granted step. It refuses steps that would leave the `[MINV, MAXV]` range and acknowledges every request.

## Interface
Parameters:
- MAXV, 3'd7, upper limit for up steps (inclusive)
- MINV, 3'd0, lower limit for down steps (inclusive); MINV < MAXV is required

Ports:
- clk3  in  1  clock; all logic on rising edge
- reset3  in  1  reset, asynchronous, active-high
- req_m  in  1  manual request, level; held until ack_m
- dir_m  in  1  manual direction, 1 = up, 0 = down; stable while req_m is high
- req_a  in  1  auto request, level; held until ack_a
- dir_a  in  1  auto direction, same encoding as dir_m
- q3  in  3  current counter value, fed back from the counter
- en3  out  1  counter enable, one-cycle pulse per issued step
- up3  out  1  counter up command; asserted only together with en3
- down3  out  1  counter down command; asserted only together with en3
- ack_m  out  1  one-cycle completion pulse to the manual requester
- ack_a  out  1  one-cycle completion pulse to the auto requester
- err  out  1  one-cycle pulse coincident with an ack when the step was refused
- busy  out  1  high in every state except IDLE

## Operation
- FSM states:
  - IDLE
  - ISSUE
  - ACK
- Reset values: all outputs 0, state IDLE, round-robin pointer = "auto last", so manual wins the first tie.
- All outputs are registered (Moore). up3 and down3 are never high together, and never high without en3.
- IDLE:
  - If any request is pending, arbitrate.
  - Single requester: grant it.
  - Both requesting: grant the requester not granted last. Update the pointer on every grant.
  - Latch the winner's id and direction.
- Range check in IDLE, using the current q3:
  - Up with q3 >= MAXV: refuse.
  - Down with q3 <= MINV: refuse.
  - Otherwise accept.
- Accepted step: IDLE -> ISSUE. In ISSUE, en3 = 1 and up3 or down3 per the latched direction. Then -> ACK.
- Refused step: IDLE -> ACK directly with err = 1. en3 is not asserted.
- ACK: pulse the winner's ack for one cycle (with err for a refused step), then -> IDLE.
- A requester must drop req in the cycle after its ack. A req still high in IDLE is treated as a new request.
- Request or direction change after the grant is ignored. The latched command completes and is acked.
- Requests arriving while busy wait. They are not lost as long as they are held.

## Timing
- Accepted step:
  - Cycle 0: IDLE samples req.
  - Cycle 1: ISSUE, en3 high.
  - Cycle 2: ACK pulse. q3 already shows the new value.
  - Request-to-ack = 2 cycles; 3 cycles per step including the return to IDLE.
- Refused step: ack + err in cycle 1; 2 cycles total.
- Back-to-back contention: grants alternate m, a, m, a…
- Maximum throughput: one step every 3 cycles.
- reset3 mid-operation (any state): immediate return to IDLE with all outputs 0. Any in-flight step is dropped without an ack. Requesters re-request after reset.

## Configuration
- Macro `CTRL3_WRAP_EN`.
- Defined: the range check is disabled. Every step is issued, so up at 7 wraps to 0 and down at 0 wraps to 7 in the counter. err is never asserted.
- Undefined (default): saturating behaviour as described in Operation.

## Structure
- Shared package `ctrl3_pkg` holds:
  - state encoding: IDLE = 2'b00, ISSUE = 2'b01, ACK = 2'b10
  - direction constants: DIR_UP = 1'b1, DIR_DN = 1'b0
  - requester ids: ID_M = 1'b0, ID_A = 1'b1
- One natural sub-module, `rr_arb2`: 2-input round-robin arbiter with grant-enable and pointer register. The FSM and range check stay in the top module.

## Test plan
- Reset then req_m = 1, dir_m = 1 with q3 = 3 -> en3 and up3 high in cycle 1, ack_m in cycle 2, err = 0, q3 = 4.
- req_m and req_a held continuously, both up, starting from q3 = 0 -> grant order m, a, m, a; q3 increments every 3 cycles.
- Without the macro, q3 = 7 and req_a up -> no en3, ack_a + err in cycle 1, q3 stays 7. Same refusal for down at q3 = 0.
- With `CTRL3_WRAP_EN`, q3 = 7 and up -> en3 issued, ack without err, q3 = 0.
- req_m dropped during ISSUE -> step still executes and ack_m still pulses. Held req after ack -> second step is issued.
- reset3 asserted during ISSUE -> next edge shows en3 = 0, no ack, busy = 0. The next tie is granted to manual.
